// File: rtl/pc_sequencer.sv
// Registered program-counter unit for the KGP_RISC fetch stage.
// Selects the next PC (seq/abs/reg/conditional/call/ret/flush) and keeps a return-address stack.
module pc_sequencer #(
    parameter int unsigned          ADDR_W    = 32,
    parameter int unsigned          RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        flush,
    input  logic [ADDR_W-1:0]           flush_pc,
    input  logic [2:0]                  branch,
    input  logic                        call,
    input  logic                        ret,
    input  logic                        carry,
    input  logic                        zero,
    input  logic                        sign,
    input  logic [ADDR_W-1:0]           rs_out,
    input  logic [ADDR_W-1:0]           pda,
    input  logic [ADDR_W-1:0]           offset,
    output logic [ADDR_W-1:0]           pc,
    output logic [ADDR_W-1:0]           next_pc,
    output logic                        taken,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_overflow,
    output logic                        ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        BR_SEQ    = 3'b000,
        BR_PDA    = 3'b001,
        BR_RS     = 3'b010,
        BR_ZERO   = 3'b011,
        BR_NZERO  = 3'b100,
        BR_CARRY  = 3'b101,
        BR_SIGN   = 3'b110,
        BR_NSIGN  = 3'b111
    } branch_e;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] branch_pc;
    logic              ras_empty;
    logic              ras_full;

    assign seq_pc    = pc_q + ADDR_W'(1);
    assign ras_top   = ras_q[ptr_q - PTR_W'(1)];
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

    // Branch decode; a failed condition falls through to the sequential PC.
    always_comb begin
        branch_pc = seq_pc;
        case (branch_e'(branch))
            BR_SEQ:   branch_pc = seq_pc;
            BR_PDA:   branch_pc = pda;
            BR_RS:    branch_pc = rs_out;
            BR_ZERO:  branch_pc = zero  ? offset : seq_pc;
            BR_NZERO: branch_pc = !zero ? offset : seq_pc;
            BR_CARRY: branch_pc = carry ? offset : seq_pc;
            BR_SIGN:  branch_pc = sign  ? offset : seq_pc;
            BR_NSIGN: branch_pc = !sign ? offset : seq_pc;
            default:  branch_pc = seq_pc;
        endcase
    end

    // Next-PC priority: flush > stall > ret > call > branch; RAS only moves when neither flush nor stall.
    always_comb begin
        pc_d   = seq_pc;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        push_d = 1'b0;
        if (flush) begin
            pc_d = flush_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (ras_empty) begin
                pc_d  = seq_pc;
                unf_d = 1'b1;
            end else begin
                pc_d  = ras_top;
                ptr_d = ptr_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (call) begin
            pc_d   = pda;
            push_d = 1'b1;
            ptr_d  = ptr_q + PTR_W'(1);
            if (ras_full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            pc_d = branch_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage needs no reset; validity is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push_d && !rst) begin
            ras_q[ptr_q] <= seq_pc;
        end
    end

    assign pc            = pc_q;
    assign next_pc       = pc_d;
    assign taken         = (pc_d != seq_pc) && (flush || !stall);
    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected values, a negedge monitor compares them.
module tb_pc_sequencer;

    localparam int S_PC    = 0;
    localparam int S_NEXT  = 1;
    localparam int S_TAKEN = 2;
    localparam int S_CNT   = 3;
    localparam int S_OVF   = 4;
    localparam int S_UNF   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, call, ret, carry, zero, sign;
    logic [31:0] flush_pc, rs_out, pda, offset;
    logic [2:0]  branch;
    logic [31:0] pc, next_pc;
    logic        taken;
    logic [2:0]  ras_count;
    logic        ras_overflow, ras_underflow;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int          q_cyc [$];
    int          q_sel [$];
    logic [31:0] q_val [$];
    string       q_tag [$];

    pc_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .branch(branch), .call(call), .ret(ret), .carry(carry), .zero(zero), .sign(sign),
        .rs_out(rs_out), .pda(pda), .offset(offset), .pc(pc), .next_pc(next_pc),
        .taken(taken), .ras_count(ras_count), .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_PC:    return pc;
            S_NEXT:  return next_pc;
            S_TAKEN: return {31'd0, taken};
            S_CNT:   return {29'd0, ras_count};
            S_OVF:   return {31'd0, ras_overflow};
            default: return {31'd0, ras_underflow};
        endcase
    endfunction

    // Monitor: every negedge, pops expectations due this cycle and compares.
    int          m_cyc;
    logic [31:0] m_val, m_act;
    string       m_tag;
    always @(negedge clk) begin
        while (q_cyc.size() != 0 && q_cyc[0] <= cyc) begin
            m_cyc = q_cyc.pop_front();
            m_val = q_val.pop_front();
            m_tag = q_tag.pop_front();
            m_act = actual(q_sel.pop_front());
            n_cmp++;
            if (m_cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: stale expectation from cycle %0d at cycle %0d", m_tag, m_cyc, cyc);
            end else if (m_act !== m_val) begin
                n_bad++;
                $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", m_tag, cyc, m_act, m_val);
            end
        end
    end

    task automatic chk(input int sel, input logic [31:0] v, input string tag);
        q_cyc.push_back(cyc);
        q_sel.push_back(sel);
        q_val.push_back(v);
        q_tag.push_back(tag);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        stall = 0; flush = 0; call = 0; ret = 0;
        carry = 0; zero = 0; sign = 0; branch = 3'b000;
        flush_pc = '0; rs_out = 32'h90; pda = 32'h80; offset = 32'h40;
    endtask

    logic [2:0]  v_br  [8] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd5};
    logic [2:0]  v_zcs [8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b010};
    logic [31:0] v_nxt [8] = '{32'h80, 32'h90, 32'h40, 32'h41, 32'h40, 32'h41, 32'h40, 32'h40};
    logic        v_tk  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] cur;
        logic [31:0] tgt;
        rst = 1'b1;
        idle_in();
        adv();
        adv();
        rst = 1'b0;

        // Reset and sequential counting
        for (int i = 0; i < 4; i++) begin
            chk(S_PC, 32'(i), "seq_pc");
            chk(S_TAKEN, 0, "seq_taken");
            chk(S_CNT, 0, "seq_cnt");
            if (i == 0) begin
                chk(S_OVF, 0, "rst_ovf");
                chk(S_UNF, 0, "rst_unf");
            end
            adv();
        end

        // Conditional branch on zero
        idle_in(); flush = 1; flush_pc = 32'd10;
        chk(S_NEXT, 32'd10, "flush_next"); chk(S_TAKEN, 1, "flush_taken");
        adv();
        idle_in(); branch = 3'b011; zero = 1;
        chk(S_PC, 32'd10, "bz_pc"); chk(S_NEXT, 32'h40, "bz_next"); chk(S_TAKEN, 1, "bz_taken");
        adv();
        idle_in(); flush = 1; flush_pc = 32'd10;
        chk(S_PC, 32'h40, "bz_after");
        adv();
        idle_in(); branch = 3'b011; zero = 0;
        chk(S_NEXT, 32'd11, "bz_fail_next"); chk(S_TAKEN, 0, "bz_fail_taken");
        adv();

        // Branch-mode table
        cur = 32'd11;
        for (int i = 0; i < 8; i++) begin
            idle_in();
            branch = v_br[i];
            {zero, carry, sign} = v_zcs[i];
            chk(S_PC, cur, "tbl_pc"); chk(S_NEXT, v_nxt[i], "tbl_next");
            chk(S_TAKEN, {31'd0, v_tk[i]}, "tbl_taken");
            adv();
            cur = v_nxt[i];
        end

        // Single call / ret
        idle_in(); flush = 1; flush_pc = 32'd5;
        chk(S_PC, cur, "tbl_last_pc");
        adv();
        idle_in(); call = 1; pda = 32'h100;
        chk(S_PC, 32'd5, "call_pc"); chk(S_NEXT, 32'h100, "call_next");
        chk(S_TAKEN, 1, "call_taken"); chk(S_CNT, 0, "call_cnt0");
        adv();
        idle_in();
        chk(S_PC, 32'h100, "call_after"); chk(S_CNT, 1, "call_cnt1");
        adv();
        idle_in(); ret = 1;
        chk(S_PC, 32'h101, "ret_pc"); chk(S_NEXT, 32'd6, "ret_next"); chk(S_TAKEN, 1, "ret_taken");
        adv();

        // Nested calls overflow the 4-deep stack
        cur = 32'd6;
        for (int k = 0; k < 5; k++) begin
            tgt = 32'h200 + 32'h100 * 32'(k);
            idle_in(); call = 1; pda = tgt;
            chk(S_PC, cur, "ncall_pc"); chk(S_NEXT, tgt, "ncall_next");
            chk(S_CNT, 32'(k), "ncall_cnt"); chk(S_OVF, 0, "ncall_ovf");
            adv();
            cur = tgt;
        end
        for (int j = 0; j < 4; j++) begin
            tgt = 32'h501 - 32'h100 * 32'(j);
            idle_in(); ret = 1;
            chk(S_PC, cur, "nret_pc"); chk(S_CNT, 32'(4 - j), "nret_cnt");
            chk(S_NEXT, tgt, "nret_next"); chk(S_TAKEN, 1, "nret_taken");
            if (j == 0) chk(S_OVF, 1, "ovf_pulse");
            if (j == 1) chk(S_OVF, 0, "ovf_clear");
            adv();
            cur = tgt;
        end
        idle_in(); ret = 1;
        chk(S_PC, 32'h201, "unf_pc"); chk(S_CNT, 0, "unf_cnt");
        chk(S_NEXT, 32'h202, "unf_next"); chk(S_TAKEN, 0, "unf_taken"); chk(S_UNF, 0, "unf_pre");
        adv();
        idle_in();
        chk(S_PC, 32'h202, "unf_after"); chk(S_UNF, 1, "unf_pulse"); chk(S_CNT, 0, "unf_cnt2");
        adv();

        // Stall holds PC and RAS; flush overrides stall
        idle_in(); call = 1; pda = 32'h700;
        chk(S_PC, 32'h203, "pre_stall_pc"); chk(S_UNF, 0, "unf_clear");
        adv();
        for (int i = 0; i < 3; i++) begin
            idle_in(); stall = 1; call = 1; pda = 32'h800;
            chk(S_PC, 32'h700, "stall_pc"); chk(S_NEXT, 32'h700, "stall_next");
            chk(S_TAKEN, 0, "stall_taken"); chk(S_CNT, 1, "stall_cnt"); chk(S_OVF, 0, "stall_ovf");
            adv();
        end
        idle_in(); stall = 1; flush = 1; flush_pc = 32'h200; call = 1; pda = 32'h800;
        chk(S_NEXT, 32'h200, "sflush_next");
        adv();
        idle_in(); ret = 1;
        chk(S_PC, 32'h200, "sflush_pc"); chk(S_CNT, 1, "sflush_cnt"); chk(S_NEXT, 32'h204, "sflush_ret");
        adv();

        // Wrap-around and asynchronous reset during a call
        idle_in(); flush = 1; flush_pc = 32'hFFFF_FFFF;
        chk(S_PC, 32'h204, "sret_pc"); chk(S_CNT, 0, "sret_cnt");
        adv();
        idle_in();
        chk(S_PC, 32'hFFFF_FFFF, "wrap_pc"); chk(S_NEXT, 0, "wrap_next"); chk(S_TAKEN, 0, "wrap_taken");
        adv();
        idle_in(); call = 1; pda = 32'h100;
        chk(S_PC, 0, "wrap_after");
        adv();
        idle_in(); call = 1; pda = 32'h300;
        #2 rst = 1'b1;
        chk(S_PC, 0, "arst_pc"); chk(S_CNT, 0, "arst_cnt");
        adv();
        chk(S_PC, 0, "rst_hold_pc");
        rst = 1'b0; idle_in();
        chk(S_NEXT, 1, "rst_rel_next");
        adv();
        chk(S_PC, 1, "rst_rel_pc");
        @(negedge clk);
        #1;
        if (q_cyc.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations never compared", q_cyc.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
